// File: rtl/line_burst_adapter.sv
// Bridges the cache's 256-bit line port to a 64-bit burst memory bus.
// Fills gather BEATS beats into one line; write-backs stream a latched line out beat by beat.
module line_burst_adapter #(
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              address_i,
  input  logic [BEAT_W*BEATS-1:0]  line_i,
  input  logic                     read_i,
  input  logic                     write_i,
  output logic [BEAT_W*BEATS-1:0]  line_o,
  output logic                     resp_o,
  output logic [31:0]              address_o,
  input  logic [BEAT_W-1:0]        burst_i,
  output logic [BEAT_W-1:0]        burst_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic                     resp_i
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  wbuf;
  logic [LINE_W-1:0]  line_q;
  logic               last_beat;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (write_i)     state_nxt = WR;
        else if (read_i) state_nxt = RD;
      end
      RD:      if (resp_i && last_beat) state_nxt = RD_DONE;
      WR:      if (resp_i && last_beat) state_nxt = WR_DONE;
      RD_DONE: state_nxt = IDLE;
      WR_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, write buffer and fill line are captured only on the accepting edge or on beat acks,
  // so later changes on the cache side cannot disturb a burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the line and write buffers are plain flops that must read zero out of reset,
      // so they are cleared here rather than left uninitialised like a RAM.
      cnt    <= '0;
      addr_q <= '0;
      wbuf   <= '0;
      line_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_i) begin
            addr_q <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            wbuf   <= line_i;
            cnt    <= '0;
          end else if (read_i) begin
            addr_q <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            cnt    <= '0;
          end
        end
        RD: begin
          if (resp_i) begin
            line_q[cnt*BEAT_W +: BEAT_W] <= burst_i;
            cnt                          <= cnt + 1'b1;
          end
        end
        WR: begin
          if (resp_i) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All bus-facing strobes decode from state and registers only.
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    unique case (state)
      RD: begin
        read_o    = 1'b1;
        address_o = addr_q;
      end
      WR: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = wbuf[cnt*BEAT_W +: BEAT_W];
      end
      RD_DONE, WR_DONE: resp_o = 1'b1;
      default: ;
    endcase
  end

  assign line_o = line_q;

endmodule
